// File: rtl/wb_arb2.sv
// -----------------------------------------------------------------------------
// wb_arb2 : two-master Wishbone arbiter with round-robin tie break.
//
// A master is granted one cycle after it raises cyc while the arbiter is idle.
// It keeps the grant until it drops cyc. Every handover passes through at
// least one idle cycle. When both masters request at once, the master that
// was not granted last time wins.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a stall watchdog. If a granted
// strobe sees no ack/err for TIMEOUT_CYCLES cycles, the arbiter answers the
// master with err, drops the slave cycle and releases the grant.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   m0_wb_* / m1_wb_*            master-side Wishbone (cyc, stb, we, adr,
//                                o_dat, sel, 4_burst, 8_burst in;
//                                i_dat, ack, err out)
//   s_wb_*                       slave-side Wishbone (mirror of the above)
//
// state | meaning
// IDLE  | no grant; slave bus and master ack/err held low
// GNT0  | master 0 owns the slave bus
// GNT1  | master 1 owns the slave bus
// -----------------------------------------------------------------------------
`ifndef WB_ADDR_W
`define WB_ADDR_W 16
`endif

module wb_arb2 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  m0_wb_cyc,
    input  logic                  m0_wb_stb,
    input  logic                  m0_wb_we,
    input  logic [`WB_ADDR_W-1:0] m0_wb_adr,
    input  logic [15:0]           m0_wb_o_dat,
    input  logic [1:0]            m0_wb_sel,
    input  logic                  m0_wb_4_burst,
    input  logic                  m0_wb_8_burst,
    output logic [15:0]           m0_wb_i_dat,
    output logic                  m0_wb_ack,
    output logic                  m0_wb_err,

    input  logic                  m1_wb_cyc,
    input  logic                  m1_wb_stb,
    input  logic                  m1_wb_we,
    input  logic [`WB_ADDR_W-1:0] m1_wb_adr,
    input  logic [15:0]           m1_wb_o_dat,
    input  logic [1:0]            m1_wb_sel,
    input  logic                  m1_wb_4_burst,
    input  logic                  m1_wb_8_burst,
    output logic [15:0]           m1_wb_i_dat,
    output logic                  m1_wb_ack,
    output logic                  m1_wb_err,

    output logic                  s_wb_cyc,
    output logic                  s_wb_stb,
    output logic                  s_wb_we,
    output logic [`WB_ADDR_W-1:0] s_wb_adr,
    output logic [15:0]           s_wb_o_dat,
    output logic [1:0]            s_wb_sel,
    output logic                  s_wb_4_burst,
    output logic                  s_wb_8_burst,
    input  logic [15:0]           s_wb_i_dat,
    input  logic                  s_wb_ack,
    input  logic                  s_wb_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;     // master granted most recently
    logic   gnt0, gnt1;
    logic   to_fire;            // watchdog expires this cycle

    assign gnt0 = (state_q == ST_GNT0);
    assign gnt1 = (state_q == ST_GNT1);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       stalled;

    // Only a live strobe of the granted master with no slave response counts.
    assign stalled = ((gnt0 & m0_wb_cyc & m0_wb_stb) | (gnt1 & m1_wb_cyc & m1_wb_stb))
                     & ~s_wb_ack & ~s_wb_err;
    assign to_fire = stalled & (cnt_q == TO_LAST);
    assign cnt_d   = (stalled & ~to_fire) ? cnt_q + 8'd1 : 8'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign to_fire            = 1'b0;
    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
`endif

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;    // master 0 wins the first tie
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_wb_cyc && m1_wb_cyc) begin
                    state_d = last_q ? ST_GNT0 : ST_GNT1;
                end else if (m0_wb_cyc) begin
                    state_d = ST_GNT0;
                end else if (m1_wb_cyc) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0_wb_cyc || to_fire) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b0;
                end
            end
            ST_GNT1: begin
                if (!m1_wb_cyc || to_fire) begin
                    state_d = ST_IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // output logic
    always_comb begin
        s_wb_cyc     = 1'b0;
        s_wb_stb     = 1'b0;
        s_wb_we      = 1'b0;
        s_wb_adr     = '0;
        s_wb_o_dat   = 16'h0000;
        s_wb_sel     = 2'b00;
        s_wb_4_burst = 1'b0;
        s_wb_8_burst = 1'b0;
        m0_wb_ack    = 1'b0;
        m0_wb_err    = 1'b0;
        m1_wb_ack    = 1'b0;
        m1_wb_err    = 1'b0;

        if (gnt0) begin
            s_wb_cyc     = m0_wb_cyc;
            s_wb_stb     = m0_wb_stb;
            s_wb_we      = m0_wb_we;
            s_wb_adr     = m0_wb_adr;
            s_wb_o_dat   = m0_wb_o_dat;
            s_wb_sel     = m0_wb_sel;
            s_wb_4_burst = m0_wb_4_burst;
            s_wb_8_burst = m0_wb_8_burst;
            if (to_fire) begin
                s_wb_cyc  = 1'b0;
                s_wb_stb  = 1'b0;
                m0_wb_err = 1'b1;
            end else begin
                // gating by cyc drops a response landing as the master leaves
                m0_wb_ack = s_wb_ack & m0_wb_cyc;
                m0_wb_err = s_wb_err & m0_wb_cyc;
            end
        end else if (gnt1) begin
            s_wb_cyc     = m1_wb_cyc;
            s_wb_stb     = m1_wb_stb;
            s_wb_we      = m1_wb_we;
            s_wb_adr     = m1_wb_adr;
            s_wb_o_dat   = m1_wb_o_dat;
            s_wb_sel     = m1_wb_sel;
            s_wb_4_burst = m1_wb_4_burst;
            s_wb_8_burst = m1_wb_8_burst;
            if (to_fire) begin
                s_wb_cyc  = 1'b0;
                s_wb_stb  = 1'b0;
                m1_wb_err = 1'b1;
            end else begin
                m1_wb_ack = s_wb_ack & m1_wb_cyc;
                m1_wb_err = s_wb_err & m1_wb_cyc;
            end
        end
    end

    assign m0_wb_i_dat = s_wb_i_dat;
    assign m1_wb_i_dat = s_wb_i_dat;

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the stalled-strobe cycle count that triggers a bus timeout (8-bit counter, legal 1..255).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have, for each master x in {m0, m1}, these Wishbone ports: mx_wb_cyc/stb/we input 1; mx_wb_adr input `WB_ADDR_W; mx_wb_o_dat input 16 (write data from master); mx_wb_sel input 2; mx_wb_4_burst, mx_wb_8_burst input 1; mx_wb_i_dat output 16; mx_wb_ack, mx_wb_err output 1.
REQ-005 SHALL have slave-side ports s_wb_cyc/stb/we output 1; s_wb_adr output `WB_ADDR_W; s_wb_o_dat output 16; s_wb_sel output 2; s_wb_4_burst, s_wb_8_burst output 1; s_wb_i_dat input 16; s_wb_ack, s_wb_err input 1.

Function
REQ-006 SHALL implement FSM states IDLE, GNT0, GNT1; state and a 1-bit last_grant register are the only arbitration state.
REQ-007 In IDLE, all s_wb_* outputs SHALL be 0 and all mx_wb_ack/err SHALL be 0.
REQ-008 In IDLE, if exactly one mx_wb_cyc=1, next state SHALL be GNTx; if both, next state SHALL be GNT for the master != last_grant (round-robin); if none, stay IDLE.
REQ-009 Grant latency SHALL be exactly one cycle: request sampled in IDLE, slave cycle visible the following cycle.
REQ-010 In GNTx, s_wb_cyc/stb/we/adr/o_dat/sel/4_burst/8_burst SHALL combinationally equal master x's inputs; mx_wb_ack/err SHALL equal s_wb_ack/err gated by mx_wb_cyc.
REQ-011 The non-granted master SHALL see ack=0 and err=0 (stalled, not rejected); both mx_wb_i_dat SHALL carry s_wb_i_dat at all times.
REQ-012 Grant SHALL be held while mx_wb_cyc=1, regardless of stb gaps or burst flags; no preemption.
REQ-013 When granted master drops cyc, next state SHALL be IDLE and last_grant SHALL update to x; at least one IDLE cycle (s_wb_cyc=0) SHALL separate consecutive grants.
REQ-014 Slave ack/err arriving in the cycle the granted master drops cyc SHALL be discarded.

Reset
REQ-015 On i_rst=1 at a clock edge: state=IDLE, last_grant=1 (m0 wins first tie), timeout counter=0; outputs SHALL be their IDLE values from the following cycle.
REQ-016 Reset asserted mid-transaction or mid-burst SHALL abort the grant without generating ack or err.

Configuration
REQ-017 With macro WB_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL increment each GNTx cycle with s_wb_stb=1 and s_wb_ack=0 and s_wb_err=0, and clear otherwise.
REQ-018 With WB_ARB_TIMEOUT_EN, when the counter equals TIMEOUT_CYCLES-1 while still stalled, the arbiter SHALL drive mx_wb_err=1 for that one cycle, force s_wb_cyc=s_wb_stb=0 in that cycle, clear the counter, and go to IDLE with last_grant=x.
REQ-019 Without WB_ARB_TIMEOUT_EN, no counter SHALL exist and a stalled slave SHALL hold the grant indefinitely.

Verification
REQ-020 Single request: m0 cyc/stb, adr=0x0040 write 0xBEEF; slave acks 2 cycles after s_wb_stb -> s_wb_cyc rises 1 cycle after m0_wb_cyc, m0_wb_ack pulses once, m1 idle signals 0.
REQ-021 Simultaneous request after reset: m0 and m1 assert cyc same cycle -> m0 granted first; after m0 drops cyc, 1 IDLE cycle, then m1 granted.
REQ-022 Round-robin: m0 and m1 continuously requesting, each transaction 1 access -> grants alternate m0,m1,m0,m1 with s_wb_cyc low one cycle between.
REQ-023 Burst hold: m1 8-burst (m1_wb_8_burst=1, 8 acks) while m0 requests at burst beat 2 -> m1 retains grant for all 8 beats, m0_wb_ack=0 throughout, m0 granted after m1 drops cyc.
REQ-024 Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks m0 stb -> m0_wb_err=1 on 4th stalled cycle, s_wb_cyc=0 that cycle; with macro undefined, grant held for 100+ cycles, no err.
REQ-025 Reset mid-burst: i_rst pulsed at beat 3 of m0 4-burst -> next cycle s_wb_cyc=0, no m0 ack/err, FSM IDLE.
